// File: rtl/sdr_rx_pkg.sv
// rtl/sdr_rx_pkg.sv - shared RX sync types, header defaults and slicer convention
package sdr_rx_pkg;

    typedef enum logic {
        SEARCH  = 1'b0,
        PAYLOAD = 1'b1
    } sync_state_t;

    // Header defaults shared with the TX header inserter
    localparam int          HDR_LEN_DEFAULT      = 16;
    localparam logic [31:0] HDR_PATTERN_DEFAULT  = 32'hF3A0_5C96;
    localparam int          PAYLOAD_SYMS_DEFAULT = 128;
    localparam int          MAX_ERR_DEFAULT      = 1;

    // Bit produced by a non-negative sample (zero included)
    localparam logic SLICE_NONNEG_BIT = 1'b1;

    function automatic logic slice_bit(input logic [11:0] s);
        return ($signed(s) >= 12'sd0) ? SLICE_NONNEG_BIT : ~SLICE_NONNEG_BIT;
    endfunction

endpackage

// File: rtl/hamming_dist.sv
// rtl/hamming_dist.sv - combinational popcount of a_i ^ b_i
module hamming_dist #(
    parameter int W = 32
) (
    input  logic [W-1:0]             a_i,
    input  logic [W-1:0]             b_i,
    output logic [$clog2(W+1)-1:0]   dist_o
);
    localparam int DW = $clog2(W+1);

    logic [W-1:0] diff;

    assign diff = a_i ^ b_i;

    always_comb begin
        dist_o = '0;
        for (int k = 0; k < W; k++) begin
            dist_o = dist_o + DW'(diff[k]);
        end
    end

endmodule

// File: rtl/header_sync.sv
// rtl/header_sync.sv - QPSK header search, header strip and payload forwarding (option macro: HEADER_SYNC_INV_EN)
module header_sync
    import sdr_rx_pkg::*;
#(
    parameter int                   HDR_LEN      = HDR_LEN_DEFAULT,
    parameter logic [2*HDR_LEN-1:0] HDR_PATTERN  = (2*HDR_LEN)'(HDR_PATTERN_DEFAULT),
    parameter int                   PAYLOAD_SYMS = PAYLOAD_SYMS_DEFAULT,
    parameter int                   MAX_ERR      = MAX_ERR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [11:0] in_i,
    input  logic [11:0] in_q,
    output logic        in_ready,
    output logic        out_valid,
    output logic [1:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        locked
);
    localparam int SW = 2 * HDR_LEN;
    localparam int FW = $clog2(HDR_LEN + 1);
    localparam int PW = $clog2(PAYLOAD_SYMS + 1);
    localparam int DW = $clog2(SW + 1);

    sync_state_t   state_q;
    // The oldest symbol of the window is shifted out before it is ever compared, so it is not kept
    logic [SW-3:0] hist_q;
    logic [SW-3:0] hist_d;
    logic [FW-1:0] fill_q;
    logic [PW-1:0] pay_cnt_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic [1:0]    out_data_q;

    logic [1:0]    sym_new;
    logic [1:0]    sym_out;
    logic [SW-1:0] candidate;
    logic [DW-1:0] dist_norm;
    logic          window_full;
    logic          match_norm;
    logic          match_any;
    logic          pay_last;

    assign sym_new     = {slice_bit(in_i), slice_bit(in_q)};
    assign candidate   = {hist_q, sym_new};
    assign hist_d      = candidate[SW-3:0];
    assign window_full = (fill_q >= FW'(HDR_LEN - 1));
    assign pay_last    = (pay_cnt_q == PW'(PAYLOAD_SYMS - 1));

    hamming_dist #(.W(SW)) u_dist_norm (
        .a_i    (candidate),
        .b_i    (HDR_PATTERN),
        .dist_o (dist_norm)
    );

    assign match_norm = window_full && (int'(dist_norm) <= MAX_ERR);

`ifdef HEADER_SYNC_INV_EN
    logic          inv_q;
    logic [DW-1:0] dist_inv;
    logic          match_inv;

    hamming_dist #(.W(SW)) u_dist_inv (
        .a_i    (candidate),
        .b_i    (~HDR_PATTERN),
        .dist_o (dist_inv)
    );

    assign match_inv = window_full && (int'(dist_inv) <= MAX_ERR);
    assign match_any = match_norm | match_inv;
    assign sym_out   = sym_new ^ {inv_q, inv_q};

    // Normal polarity wins when both patterns are within tolerance
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (state_q == SEARCH && in_valid && match_any) begin
            inv_q <= ~match_norm;
        end
    end
`else
    assign match_any = match_norm;
    assign sym_out   = sym_new;
`endif

    assign in_ready  = (state_q == SEARCH) | ~out_valid_q | out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign locked    = (state_q == PAYLOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            pay_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 2'b00;
        end else begin
            // A final symbol may still drain here after the state is back in SEARCH
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            case (state_q)
                SEARCH: begin
                    if (in_valid) begin
                        hist_q <= hist_d;
                        if (fill_q != FW'(HDR_LEN)) begin
                            fill_q <= fill_q + FW'(1);
                        end
                        if (match_any) begin
                            state_q   <= PAYLOAD;
                            pay_cnt_q <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (in_valid && in_ready) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= sym_out;
                        out_last_q  <= pay_last;
                        if (pay_last) begin
                            state_q   <= SEARCH;
                            hist_q    <= '0;
                            fill_q    <= '0;
                            pay_cnt_q <= '0;
                        end else begin
                            pay_cnt_q <= pay_cnt_q + PW'(1);
                        end
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_header_sync.sv
// tb/tb_header_sync.sv - randomized directed bench for header_sync against a window-scanning reference model
module tb_header_sync;

    localparam int          H    = 16;
    localparam logic [31:0] PAT  = 32'hF3A0_5C96;
    localparam int          PAY  = 128;
    localparam int          MAXE = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_i = '0;
    logic [11:0] in_q = '0;
    logic        in_ready;
    logic        out_valid;
    logic [1:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        locked;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] sent_q[$];
    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];
    logic [1:0] orig_q[$];
    bit         rand_rdy = 1'b0;
    bit         prev_stall = 1'b0;
    logic       prev_last = 1'b0;
    logic [1:0] prev_data = '0;

    header_sync #(
        .HDR_LEN      (H),
        .HDR_PATTERN  (PAT),
        .PAYLOAD_SYMS (PAY),
        .MAX_ERR      (MAXE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] mk_sample(input logic b);
        if (b && $urandom_range(0, 7) == 0) return 12'h000;
        return {~b, 11'($urandom_range(0, 2047))};
    endfunction

    function automatic logic [1:0] pat_sym(input logic [31:0] p, input int j);
        return p[2*(H-1-j) +: 2];
    endfunction

    function automatic int win_dist(input logic [1:0] win[$], input logic [31:0] p);
        int d = 0;
        foreach (win[j]) d += $countones(win[j] ^ pat_sym(p, j));
        return d;
    endfunction

    // Reference: slide an H-symbol window over everything accepted since reset
    task automatic build_expected();
        logic [1:0] win[$];
        int         left = 0;
        logic [1:0] flip = 2'b00;
        exp_q.delete();
        foreach (sent_q[k]) begin
            if (left > 0) begin
                left--;
                exp_q.push_back({left == 0, sent_q[k] ^ flip});
            end else begin
                win.push_back(sent_q[k]);
                if (win.size() > H) void'(win.pop_front());
                if (win.size() == H) begin
                    if (win_dist(win, PAT) <= MAXE) begin
                        left = PAY; flip = 2'b00; win.delete();
                    end
`ifdef HEADER_SYNC_INV_EN
                    else if (win_dist(win, ~PAT) <= MAXE) begin
                        left = PAY; flip = 2'b11; win.delete();
                    end
`endif
                end
            end
        end
    endtask

    task automatic compare_stream(input string tag, input bit partial);
        build_expected();
        if (partial) chk({tag, "_len"}, 32'(got_q.size() <= exp_q.size()), 32'd1);
        else         chk({tag, "_len"}, got_q.size(), exp_q.size());
        foreach (got_q[k]) begin
            if (k < exp_q.size()) chk($sformatf("%s_sym%0d", tag, k), got_q[k], exp_q[k]);
        end
    endtask

    task automatic send_sym(input logic [1:0] s);
        bit acc = 1'b0;
        in_i = mk_sample(s[1]);
        in_q = mk_sample(s[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (acc) sent_q.push_back(s);
        else chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_header(input logic [31:0] p);
        for (int j = 0; j < H; j++) send_sym(pat_sym(p, j));
    endtask

    task automatic send_payload(input int n);
        for (int k = 0; k < n; k++) send_sym(2'($urandom_range(0, 3)));
    endtask

    task automatic drain();
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        sent_q.delete();
        rst = 1'b0;
    endtask

    function automatic int count_lasts();
        int n = 0;
        foreach (got_q[k]) n += int'(got_q[k][2]);
        return n;
    endfunction

    always @(negedge clk) begin
        if (prev_stall)
            chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
        if (!rst)
            chk("in_ready", 32'(in_ready), 32'(locked ? (!out_valid || out_ready) : 1'b1));
        if (out_valid && out_ready) got_q.push_back({out_last, out_data});
        prev_stall = out_valid && !out_ready && !rst;
        prev_last  = out_last;
        prev_data  = out_data;
    end

    initial begin
        int b1;
        int b2;

        // Zero samples (slice to 11) while reset is held must not cause a lock
        rst = 1'b1; in_valid = 1'b1; in_i = '0; in_q = '0;
        repeat (15) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_locked",    32'(locked),    32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0;
        got_q.delete(); sent_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("prefix_nolock", 32'(locked), 32'd0);

        // Exact header, full-rate output
        for (int j = 0; j < H; j++) begin
            send_sym(pat_sym(PAT, j));
            if (j == H - 2) chk("lock_early", 32'(locked), 32'd0);
        end
        chk("lock_after_hdr", 32'(locked), 32'd1);
        send_payload(PAY);
        chk("unlock_after_last", 32'(locked), 32'd0);
        drain();
        compare_stream("exact", 1'b0);
        chk("exact_count", got_q.size(), PAY);
        chk("exact_lasts", count_lasts(), 1);

        // One flipped bit is tolerated
        do_reset();
        b1 = $urandom_range(0, 31);
        send_header(PAT ^ (32'd1 << b1));
        chk("flip1_lock", 32'(locked), 32'd1);
        send_payload(PAY);
        drain();
        compare_stream("flip1", 1'b0);

        // Two flipped bits are rejected; following samples never appear
        do_reset();
        b1 = $urandom_range(0, 31);
        b2 = (b1 + 1 + $urandom_range(0, 30)) % 32;
        send_header(PAT ^ (32'd1 << b1) ^ (32'd1 << b2));
        chk("flip2_nolock", 32'(locked), 32'd0);
        send_payload(20);
        drain();
        chk("flip2_no_out", got_q.size(), 0);
        compare_stream("flip2", 1'b0);

        // Random downstream backpressure
        do_reset();
        rand_rdy = 1'b1;
        send_header(PAT);
        send_payload(PAY);
        drain();
        compare_stream("bp", 1'b0);
        chk("bp_count", got_q.size(), PAY);

        // Two frames with no gap between last payload and next header
        do_reset();
        send_header(PAT);
        send_payload(PAY);
        send_header(PAT);
        send_payload(PAY);
        drain();
        compare_stream("b2b", 1'b0);
        chk("b2b_count", got_q.size(), 2 * PAY);
        chk("b2b_lasts", count_lasts(), 2);

        // Reset in the middle of a frame, then a clean frame
        do_reset();
        send_header(PAT);
        send_payload(60);
        compare_stream("pre_rst", 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_locked",    32'(locked),    32'd0);
        #1;
        got_q.delete(); sent_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send_header(PAT);
        send_payload(PAY);
        drain();
        compare_stream("post_rst", 1'b0);
        chk("post_rst_lasts", count_lasts(), 1);

        // Inverted header and inverted payload (180 degree ambiguity)
        do_reset();
        orig_q.delete();
        send_header(~PAT);
        for (int k = 0; k < PAY; k++) begin
            orig_q.push_back(2'($urandom_range(0, 3)));
            send_sym(orig_q[k] ^ 2'b11);
        end
        drain();
        compare_stream("inv", 1'b0);
`ifdef HEADER_SYNC_INV_EN
        chk("inv_count", got_q.size(), PAY);
        foreach (got_q[k]) begin
            if (k < PAY) chk($sformatf("inv_orig%0d", k), got_q[k][1:0], orig_q[k]);
        end
`else
        chk("inv_no_out", got_q.size(), 0);
        chk("inv_nolock", 32'(locked), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/header_sync.md
Name: header_sync

Overview:
- RX-side counterpart of the TX header inserter.
- Consumes QPSK I/Q samples (12-bit each) and hard-slices each sample to a 2-bit symbol.
- Searches for the known header symbol pattern, tolerating a configurable number of bit errors. Once found, strips the header and forwards exactly PAYLOAD_SYMS payload symbols as a 2-bit stream (last flagged), then re-arms the search.
- Sits between the RX matched filter and the 2->1 stream_resizer feeding the BCH decoder.

Parameters:
- HDR_LEN, 16, header length in symbols (2..32).
- HDR_PATTERN, 32'hF3A0_5C96, header bits, 2*HDR_LEN wide; the first transmitted symbol occupies the MSB pair, and each symbol is {i_bit,q_bit}.
- PAYLOAD_SYMS, 128, payload symbols forwarded per frame (>=1).
- MAX_ERR, 1, maximum Hamming distance (in bits) accepted as a header match.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample valid
- in_i  in  12  I sample, two's complement
- in_q  in  12  Q sample, two's complement
- in_ready  out  1  input ready
- out_valid  out  1  payload symbol valid
- out_data  out  2  {i_bit,q_bit}; MSB = I
- out_last  out  1  high with the final payload symbol of a frame
- out_ready  in  1  downstream ready
- locked  out  1  high while in PAYLOAD state

Behaviour:
- One clock domain. Reset is synchronous and active-high, with ports named clk/rst.
- Slicer: i_bit = ~in_i[11], q_bit = ~in_q[11]. A positive or zero sample maps to 1.
- Transfers occur only when valid&&ready on the same edge.
- Reset values:
  - out_valid=0, out_last=0, out_data=0, locked=0.
  - State=SEARCH, shift register=0, fill counter=0, payload counter=0.
- A reset mid-frame discards all partial state. No out_last is emitted for the aborted frame.
- SEARCH state:
  - in_ready=1 unconditionally, so samples are never stalled.
  - Each accepted symbol shifts into a 2*HDR_LEN-bit register (new symbol enters at the LSB pair).
  - The fill counter saturates at HDR_LEN.
  - Candidate = {shreg[2*HDR_LEN-3:0], sym_new}.
  - Match is true when fill>=HDR_LEN-1 before the shift (i.e. at least HDR_LEN symbols including the current one) and popcount(candidate ^ HDR_PATTERN) <= MAX_ERR.
  - On match, go to PAYLOAD at the next edge. Header symbols are never output.
- PAYLOAD state:
  - Output is a single registered stage.
  - in_ready = ~out_valid | out_ready.
  - Each accepted sample loads out_data and sets out_valid=1, and increments the payload counter.
  - When the loaded symbol is number PAYLOAD_SYMS, out_last=1 with it, the state returns to SEARCH, and the fill counter and shift register are cleared at the same edge.
  - If out_valid && out_ready and no new load occurs, out_valid drops to 0.
  - out_data and out_last stay stable while out_valid && !out_ready.
- Latency: first payload symbol is visible on out_valid one cycle after it is accepted.
- The fill counter and shift register are not cleared again on entry to PAYLOAD.
- locked = (state == PAYLOAD).
- locked falls on the same edge that loads the last symbol. The final symbol may still be pending on the output while SEARCH already accepts new samples; this is legal because SEARCH never drives the output register.
- Back-to-back frames: a header starting on the sample immediately after the last payload symbol must be detected.
- MAX_ERR=0 requires an exact match.
- The 12-bit value 0 slices to bit 1.

Optional Feature:
- Macro: HEADER_SYNC_INV_EN.
- Defined:
  - SEARCH also matches the bitwise-inverted pattern, popcount(candidate ^ ~HDR_PATTERN) <= MAX_ERR, which covers 180° carrier ambiguity.
  - An inv flag is latched on match, and payload bits are XORed with {inv,inv}.
  - If both the normal and inverted patterns match, the normal pattern wins (inv=0).
  - inv resets to 0.
- Undefined: only the normal pattern is searched, and no inversion logic exists.

Decomposition:
- Shared package sdr_rx_pkg:
  - State typedef (SEARCH, PAYLOAD).
  - Default header pattern and length constants, shared with the TX header block.
  - Slicer sign convention constant.
- Sub-module hamming_dist:
  - Parameter W.
  - Combinational popcount of a ^ b.
  - Output width clog2(W+1).

Test Plan:
- Exact header then 128 payload samples, out_ready=1:
  - locked rises after header symbol 16.
  - Exactly 128 outputs match the slicer, and out_last is high only on the 128th.
  - No header symbols appear on the output.
- Header with 1 bit flipped (MAX_ERR=1) -> lock. Header with 2 bits flipped -> no lock, and the following samples are never output.
- Random out_ready (50%) during payload:
  - out_data/out_last stay stable while stalled.
  - in_ready = ~out_valid|out_ready.
  - The count is exactly 128 and the order is preserved.
- Two frames back-to-back with zero gap -> 256 outputs and two out_last pulses. All-zero-sample prefix of 15 symbols before reset release produces no false lock.
- Reset asserted at payload symbol 60 -> the next cycle has out_valid=0 and locked=0. A subsequent full frame is received correctly.
- With HEADER_SYNC_INV_EN: inverted header followed by inverted payload -> output equals the original payload bits. Without the macro, the same stimulus gives no lock.
